// File: rtl/afifo_pingpong_ctrl.sv
// Ping-pong sequencer for the double-buffered activation FIFO pair of one PE column.
// Chooses the compute FIFO, issues its reads and counts fills of the shadow FIFO.
module afifo_pingpong_ctrl #(
    parameter int NB_DATA = 8,
    parameter int LEN_W   = 4,
    parameter int TILE_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic [LEN_W-1:0]  tile_len,
    input  logic              shadow_write_in,
    input  logic              compute_empty,
    input  logic              consumer_ready,
    output logic              which_afifo,
    output logic              compute_read,
    output logic              read_delay_en,
    output logic [TILE_W-1:0] tile_idx,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRELOAD,
        S_COMPUTE,
        S_WAIT_SHADOW,
        S_SWAP,
        S_DONE
    } state_e;

    localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(NB_DATA);

    state_e              state_q, state_d;
    logic [TILE_W-1:0]   num_q, num_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic [LEN_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic [TILE_W-1:0]   tile_idx_q, tile_idx_d;
    logic                which_q, which_d;
    logic                err_q, err_d;
    logic                first_q, first_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                rd_en;
    logic                wr_full;
    logic                last_tile;
    logic                counting_writes;

    assign wr_full         = (wr_cnt_q == len_q);
    assign last_tile       = (tile_idx_q == num_q - TILE_W'(1));
    assign counting_writes = (state_q == S_PRELOAD) || (state_q == S_COMPUTE) ||
                             (state_q == S_WAIT_SHADOW);
    assign rd_en           = (state_q == S_COMPUTE) && consumer_ready && !compute_empty &&
                             (rd_cnt_q < len_q);

    // NOTE: every signal written here gets a default first, so no path leaves a latch.
    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        len_d      = len_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        tile_idx_d = tile_idx_q;
        which_d    = which_q;
        err_d      = err_q;
        first_d    = first_q;

        if (rd_en) begin
            rd_cnt_d = rd_cnt_q + LEN_W'(1);
        end

        // Shadow fills: saturate at a full tile; overflow or a fill during the last tile is an error.
        if (shadow_write_in) begin
            if (counting_writes) begin
                if (wr_full || ((state_q == S_COMPUTE) && last_tile)) begin
                    err_d = 1'b1;
                end else begin
                    wr_cnt_d = wr_cnt_q + LEN_W'(1);
                end
            end else if (state_q == S_SWAP) begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d      = num_tiles;
                    len_d      = tile_len;
                    err_d      = 1'b0;
                    rd_cnt_d   = '0;
                    wr_cnt_d   = '0;
                    tile_idx_d = '0;
                    first_d    = 1'b1;
                    if ((num_tiles == '0) || (tile_len == '0)) begin
                        state_d = S_DONE;
                    end else if ({1'b0, tile_len} > MAX_LEN) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_PRELOAD;
                    end
                end
            end
            S_PRELOAD: begin
                if (wr_cnt_d == len_q) begin
                    state_d = S_SWAP;
                end
            end
            S_SWAP: begin
                which_d  = !which_q;
                rd_cnt_d = '0;
                wr_cnt_d = '0;
                first_d  = 1'b0;
                if (!first_q) begin
                    tile_idx_d = tile_idx_q + TILE_W'(1);
                end
                state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                // Next-count compares let a final read and a completing fill swap directly.
                if (rd_cnt_d == len_q) begin
                    if (last_tile) begin
                        state_d = S_DONE;
                    end else if (wr_cnt_d == len_q) begin
                        state_d = S_SWAP;
                    end else begin
                        state_d = S_WAIT_SHADOW;
                    end
                end
            end
            S_WAIT_SHADOW: begin
                if (wr_cnt_d == len_q) begin
                    state_d = S_SWAP;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            num_q      <= '0;
            len_q      <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            tile_idx_q <= '0;
            which_q    <= 1'b0;
            err_q      <= 1'b0;
            first_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            len_q      <= len_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            tile_idx_q <= tile_idx_d;
            which_q    <= which_d;
            err_q      <= err_d;
            first_q    <= first_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign which_afifo   = which_q;
    assign compute_read  = rd_en;
    assign tile_idx      = tile_idx_q;
    assign busy          = busy_q;
    assign read_delay_en = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_afifo_pingpong_ctrl.sv
// Directed bench for afifo_pingpong_ctrl: cycle-exact stimulus schedules with hand-derived expectations.
module tb_afifo_pingpong_ctrl;

    localparam int TILE_W = 8;
    localparam int LEN_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [TILE_W-1:0] num_tiles;
    logic [LEN_W-1:0]  tile_len;
    logic              shadow_write_in;
    logic              compute_empty;
    logic              consumer_ready;
    logic              which_afifo;
    logic              compute_read;
    logic              read_delay_en;
    logic [TILE_W-1:0] tile_idx;
    logic              busy;
    logic              done;
    logic              err;

    afifo_pingpong_ctrl #(.NB_DATA(8), .LEN_W(LEN_W), .TILE_W(TILE_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .num_tiles       (num_tiles),
        .tile_len        (tile_len),
        .shadow_write_in (shadow_write_in),
        .compute_empty   (compute_empty),
        .consumer_ready  (consumer_ready),
        .which_afifo     (which_afifo),
        .compute_read    (compute_read),
        .read_delay_en   (read_delay_en),
        .tile_idx        (tile_idx),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Activity observed mid-cycle, while inputs are stable.
    int          n_reads;
    int          n_done;
    int          n_wt;
    int          n_tt;
    logic        which_log [8];
    logic [7:0]  tile_log  [8];
    logic        last_which;
    logic [7:0]  last_tile;

    always @(negedge clk) begin
        if (compute_read) n_reads++;
        if (done) n_done++;
        if (which_afifo != last_which) begin
            if (n_wt < 8) which_log[n_wt] = which_afifo;
            n_wt++;
        end
        if (tile_idx != last_tile) begin
            if (n_tt < 8) tile_log[n_tt] = tile_idx;
            n_tt++;
        end
        last_which = which_afifo;
        last_tile  = tile_idx;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic clear_obs();
        n_reads = 0;
        n_done  = 0;
        n_wt    = 0;
        n_tt    = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_obs();
    endtask

    task automatic do_start(input int n, input int l);
        num_tiles = TILE_W'(n);
        tile_len  = LEN_W'(l);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drive(input logic w);
        shadow_write_in = w;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        logic got;
        got = 1'b0;
        shadow_write_in = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check(tag, 32'(got), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        start           = 1'b0;
        num_tiles       = '0;
        tile_len        = '0;
        shadow_write_in = 1'b0;
        compute_empty   = 1'b0;
        consumer_ready  = 1'b1;
        last_which      = 1'b0;
        last_tile       = '0;
        clear_obs();
        #3;
        check("rst_which", 32'(which_afifo), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_tile", 32'(tile_idx), 0);
        check("rst_rd", 32'(compute_read), 0);
        check("rst_rde", 32'(read_delay_en), 0);
        @(posedge clk);
        #1;
        apply_reset();

        // 1: single tile of 4
        do_start(1, 4);
        check("t1_busy", 32'(busy), 1);
        check("t1_rde", 32'(read_delay_en), 1);
        repeat (4) drive(1'b1);
        wait_done("t1_done", 30);
        check("t1_reads", 32'(n_reads), 4);
        check("t1_which", 32'(which_afifo), 1);
        check("t1_nswap", 32'(n_wt), 1);
        check("t1_ndone", 32'(n_done), 1);
        check("t1_err", 32'(err), 0);
        check("t1_idle", 32'(busy), 0);
        check("t1_tile", 32'(tile_idx), 0);

        // 2: three tiles of 8, shadow fills overlapped with compute reads
        apply_reset();
        do_start(3, 8);
        repeat (8) drive(1'b1);
        drive(1'b0);
        repeat (8) drive(1'b1);
        drive(1'b0);
        repeat (8) drive(1'b1);
        wait_done("t2_done", 30);
        check("t2_reads", 32'(n_reads), 24);
        check("t2_nswap", 32'(n_wt), 3);
        check("t2_which0", 32'(which_log[0]), 1);
        check("t2_which1", 32'(which_log[1]), 0);
        check("t2_which2", 32'(which_log[2]), 1);
        check("t2_ntile", 32'(n_tt), 2);
        check("t2_tile1", 32'(tile_log[0]), 1);
        check("t2_tile2", 32'(tile_log[1]), 2);
        check("t2_err", 32'(err), 0);
        check("t2_ndone", 32'(n_done), 1);

        // 3: compute drains before the shadow fills -> WAIT_SHADOW
        apply_reset();
        do_start(2, 4);
        repeat (4) drive(1'b1);
        repeat (5) drive(1'b0);
        check("t3_reads0", 32'(n_reads), 4);
        for (int i = 0; i < 5; i++) begin
            shadow_write_in = 1'b0;
            #2;
            check("t3_wait_rd", 32'(compute_read), 0);
            @(posedge clk);
            #1;
        end
        check("t3_wait_busy", 32'(busy), 1);
        check("t3_wait_which", 32'(which_afifo), 1);
        for (int i = 0; i < 4; i++) begin
            shadow_write_in = 1'b1;
            #2;
            check("t3_fill_rd", 32'(compute_read), 0);
            @(posedge clk);
            #1;
        end
        wait_done("t3_done", 30);
        check("t3_reads", 32'(n_reads), 8);
        check("t3_which", 32'(which_afifo), 0);
        check("t3_tile", 32'(tile_idx), 1);
        check("t3_err", 32'(err), 0);

        // 4: oversize tile and zero-tile jobs
        apply_reset();
        do_start(1, 9);
        check("t4_done", 32'(done), 1);
        check("t4_err", 32'(err), 1);
        @(posedge clk);
        #1;
        check("t4_done_pulse", 32'(done), 0);
        check("t4_idle", 32'(busy), 0);
        check("t4_err_sticky", 32'(err), 1);
        check("t4_reads", 32'(n_reads), 0);
        do_start(0, 4);
        check("t4z_done", 32'(done), 1);
        check("t4z_err", 32'(err), 0);
        @(posedge clk);
        #1;
        do_start(2, 0);
        check("t4l_done", 32'(done), 1);
        check("t4l_err", 32'(err), 0);
        @(posedge clk);
        #1;

        // 5: shadow overflow and read gating
        apply_reset();
        do_start(2, 2);
        repeat (2) drive(1'b1);
        drive(1'b0);
        consumer_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) check("t5_err_pre", 32'(err), 0);
            shadow_write_in = 1'b1;
            #2;
            check("t5_notready_rd", 32'(compute_read), 0);
            @(posedge clk);
            #1;
        end
        shadow_write_in = 1'b0;
        consumer_ready  = 1'b1;
        compute_empty   = 1'b1;
        check("t5_err_set", 32'(err), 1);
        #2;
        check("t5_empty_rd", 32'(compute_read), 0);
        @(posedge clk);
        #1;
        compute_empty = 1'b0;
        #2;
        check("t5_go_rd", 32'(compute_read), 1);
        wait_done("t5_done", 30);
        check("t5_reads", 32'(n_reads), 4);
        check("t5_err_hold", 32'(err), 1);
        do_start(1, 1);
        check("t5_err_clr", 32'(err), 0);
        drive(1'b1);
        wait_done("t5b_done", 20);
        check("t5b_err", 32'(err), 0);

        // 6: reset in the middle of COMPUTE
        apply_reset();
        consumer_ready = 1'b0;
        do_start(1, 4);
        repeat (4) drive(1'b1);
        drive(1'b0);
        check("t6_which_pre", 32'(which_afifo), 1);
        check("t6_busy_pre", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("t6_which", 32'(which_afifo), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_tile", 32'(tile_idx), 0);
        check("t6_err", 32'(err), 0);
        check("t6_rde", 32'(read_delay_en), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        consumer_ready = 1'b1;
        clear_obs();
        do_start(1, 2);
        check("t6_restart_busy", 32'(busy), 1);
        repeat (2) drive(1'b1);
        drive(1'b0);
        check("t6_restart_which", 32'(which_afifo), 1);
        wait_done("t6_restart_done", 20);
        check("t6_restart_reads", 32'(n_reads), 2);
        check("t6_restart_err", 32'(err), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
